lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_pkg.sv | 19 +
 rtl/lfsr_next_bit.sv | 11 +
 rtl/lfsr_checker.sv | 145 ++++++++++++++
 tb/tb_lfsr_checker.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 32-bit XNOR LFSR generator and checker pair.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_SEED  = 2'd0,
        ST_CHECK = 2'd1,
        ST_LOST  = 2'd2
    } lfsr_state_e;

    localparam int TAP_A = 31;
    localparam int TAP_B = 21;
    localparam int TAP_C = 1;
    localparam int TAP_D = 0;

    // All-ones is the one state an XNOR LFSR can never leave.
    localparam logic [31:0] LFSR_LOCKUP       = 32'hFFFF_FFFF;
    localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h0FFF_0FFF;

endpackage

// File: rtl/lfsr_next_bit.sv
// Combinational XNOR feedback of the 32-bit LFSR; shared by generator and checker.
module lfsr_next_bit
    import lfsr_pkg::*;
(
    input  logic [31:0] state_i,
    output logic        bit_o
);

    assign bit_o = ~(state_i[TAP_A] ^ state_i[TAP_B] ^ state_i[TAP_C] ^ state_i[TAP_D]);

endmodule

// File: rtl/lfsr_checker.sv
// Seeds from 32 received bits, then free-runs and flags mismatches; drops lock on too many misses.
// The err_count/clear_err path is built only when LFSR_CHECKER_ERRCNT_EN is defined.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int MISS_LIMIT = 8,
    parameter int WINDOW     = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        bit_in,
    input  logic        clear_err,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [1:0]  state
);

    localparam int WIN_W  = $clog2(WINDOW);
    localparam int MISS_W = $clog2(MISS_LIMIT + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    lfsr_state_e       state_q, state_d;
    logic [31:0]       shift_q, shift_d;
    logic [4:0]        seed_cnt_q, seed_cnt_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              err_pulse_q, err_pulse_d;
    logic [31:0]       seeded;
    logic              pred_bit;
    logic              mismatch;

    lfsr_next_bit u_next_bit (
        .state_i (shift_q),
        .bit_o   (pred_bit)
    );

    assign seeded = {shift_q[30:0], bit_in};

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        seed_cnt_d  = seed_cnt_q;
        win_cnt_d   = win_cnt_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        mismatch    = 1'b0;
        unique case (state_q)
            ST_SEED: begin
                if (enable) begin
                    shift_d = seeded;
                    if (seed_cnt_q == 5'd31) begin
                        seed_cnt_d = '0;
                        // A lockup seed would predict ones forever, so keep seeding.
                        if (seeded != LFSR_LOCKUP) begin
                            state_d   = ST_CHECK;
                            win_cnt_d = '0;
                            miss_d    = '0;
                        end
                    end else begin
                        seed_cnt_d = seed_cnt_q + 5'd1;
                    end
                end
            end
            ST_CHECK: begin
                if (enable) begin
                    shift_d     = {shift_q[30:0], pred_bit};
                    mismatch    = pred_bit ^ bit_in;
                    err_pulse_d = mismatch;
                    win_cnt_d   = win_cnt_q + WIN_W'(1);
                    // The wrap bit opens the next window, so its miss starts the new count.
                    if (win_cnt_q == WIN_LAST) begin
                        miss_d = MISS_W'(mismatch);
                    end else begin
                        miss_d = miss_q + MISS_W'(mismatch);
                    end
                    if (miss_d >= MISS_W'(MISS_LIMIT)) begin
                        state_d = ST_LOST;
                    end
                end
            end
            ST_LOST: begin
                state_d    = ST_SEED;
                shift_d    = '0;
                seed_cnt_d = '0;
                win_cnt_d  = '0;
                miss_d     = '0;
            end
            default: begin
                state_d = ST_SEED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_SEED;
            shift_q     <= '0;
            seed_cnt_q  <= '0;
            win_cnt_q   <= '0;
            miss_q      <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            seed_cnt_q  <= seed_cnt_d;
            win_cnt_q   <= win_cnt_d;
            miss_q      <= miss_d;
            err_pulse_q <= err_pulse_d;
        end
    end

`ifdef LFSR_CHECKER_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clear_err) begin
            err_cnt_d = '0;
        end else if (mismatch && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    logic unused_clear_err;
    assign unused_clear_err = clear_err;
    assign err_count        = '0;
`endif

    assign locked    = (state_q == ST_CHECK);
    assign err_pulse = err_pulse_q;
    assign state     = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: reference generator plus behavioural scoreboard of lock/error outputs.
module tb_lfsr_checker;

    localparam int MISS_LIMIT = 8;
    localparam int WINDOW     = 256;
`ifdef LFSR_CHECKER_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        enable;
    logic        bit_in;
    logic        clear_err;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [18:0] exp_q[$];

    // Reference generator and behavioural model of the checker outputs.
    logic [31:0] gen_q;
    logic [1:0]  m_state;
    int          m_cnt;
    logic        m_ones;
    int          m_win;
    int          m_miss;
    logic        m_pulse;
    logic [15:0] m_err;
    logic [15:0] err_base;

    lfsr_checker #(
        .MISS_LIMIT (MISS_LIMIT),
        .WINDOW     (WINDOW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .bit_in    (bit_in),
        .clear_err (clear_err),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 2'd0;
        m_cnt   = 0;
        m_ones  = 1'b1;
        m_win   = 0;
        m_miss  = 0;
        m_pulse = 1'b0;
        m_err   = 16'd0;
    endtask

    task automatic model_edge(input logic en, input logic flip, input logic clr, input logic b);
        m_pulse = 1'b0;
        case (m_state)
            2'd2: begin
                m_state = 2'd0;
                m_cnt   = 0;
                m_ones  = 1'b1;
            end
            2'd0: begin
                if (en) begin
                    m_ones = m_ones & b;
                    m_cnt++;
                    if (m_cnt == 32) begin
                        m_cnt = 0;
                        if (!m_ones) begin
                            m_state = 2'd1;
                            m_win   = 0;
                            m_miss  = 0;
                        end
                        m_ones = 1'b1;
                    end
                end
            end
            2'd1: begin
                if (en) begin
                    m_pulse = flip;
                    if (ERRCNT && flip && m_err != 16'hFFFF) m_err = m_err + 16'd1;
                    if (m_win == WINDOW - 1) m_miss = int'(flip);
                    else m_miss = m_miss + int'(flip);
                    m_win = (m_win + 1) % WINDOW;
                    if (m_miss >= MISS_LIMIT) m_state = 2'd2;
                end
            end
            default: m_state = 2'd0;
        endcase
        if (ERRCNT && clr) m_err = 16'd0;
    endtask

    // One clock of stimulus: drive at the falling edge, compare just after the rising edge.
    task automatic step(input logic en, input logic flip, input logic clr, input logic force_one);
        logic        b;
        logic        fb;
        logic [18:0] e;
        @(negedge clk);
        b = 1'b0;
        if (en) begin
            if (force_one) begin
                b = 1'b1;
            end else begin
                fb    = ~(gen_q[31] ^ gen_q[21] ^ gen_q[1] ^ gen_q[0]);
                gen_q = {gen_q[30:0], fb};
                b     = fb ^ flip;
            end
        end
        enable    = en;
        bit_in    = b;
        clear_err = clr;
        model_edge(en, flip & ~force_one, clr, b);
        exp_q.push_back({m_state, m_pulse, m_err});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("state", 32'(state), 32'(e[18:17]));
        check("locked", 32'(locked), 32'(e[18:17] == 2'd1));
        check("err_pulse", 32'(err_pulse), 32'(e[16]));
        check("err_count", 32'(err_count), 32'(e[15:0]));
        enable    = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic align_window();
        for (int i = 0; i < WINDOW; i++) begin
            if (m_win == 0) break;
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        enable    = 1'b0;
        bit_in    = 1'b0;
        clear_err = 1'b0;
        reset     = 1'b1;
        gen_q     = 32'h0FFF_0FFF;
        model_reset();
        #2;
        do_reset("por");
        @(negedge clk);

        // Seed from the generator: lock appears on the 32nd bit's edge.
        clean(31);
        check("seed31_locked", 32'(locked), 32'd0);
        clean(1);
        check("seed32_locked", 32'(locked), 32'd1);

        // Long clean run with occasional enable gaps.
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 7) != 0), 1'b0, 1'b0, 1'b0);
        end
        check("clean_err_count", 32'(err_count), 32'd0);
        check("clean_locked", 32'(locked), 32'd1);

        // Single flip.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("flip1_pulse", 32'(err_pulse), 32'd1);
        check("flip1_count", 32'(err_count), ERRCNT ? 32'd1 : 32'd0);
        clean(1);
        check("flip1_pulse_gone", 32'(err_pulse), 32'd0);
        check("flip1_locked", 32'(locked), 32'd1);
        clean(20);

        // Seven misses in one window, one after the wrap: lock is kept.
        align_window();
        err_base = err_count;
        for (int i = 0; i < MISS_LIMIT - 1; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            clean(10);
        end
        align_window();
        clean(10);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("wrap_locked", 32'(locked), 32'd1);
        check("wrap_err_count", 32'(err_count), ERRCNT ? 32'(err_base + 16'd8) : 32'd0);
        clean(5);

        // Eight misses in one window: LOST for one clock, then reseed.
        align_window();
        for (int i = 0; i < MISS_LIMIT - 1; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            clean(5);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("lost_state", 32'(state), 32'd2);
        check("lost_locked", 32'(locked), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("after_lost_state", 32'(state), 32'd0);
        clean(32);
        check("relock_locked", 32'(locked), 32'd1);

        // All-ones seed is rejected, then a valid stream locks.
        do_reset("ones");
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        check("ones_state", 32'(state), 32'd0);
        clean(31);
        check("ones_relock31", 32'(locked), 32'd0);
        clean(1);
        check("ones_relock32", 32'(locked), 32'd1);

`ifdef LFSR_CHECKER_ERRCNT_EN
        // Saturation and clear priority.
        align_window();
        dut.err_cnt_q = 16'hFFFE;
        m_err         = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            clean(3);
        end
        check("sat_err_count", 32'(err_count), 32'hFFFF);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("clr_err_count", 32'(err_count), 32'd0);
        check("clr_pulse", 32'(err_pulse), 32'd1);
        clean(5);
`endif

        // Reset mid-CHECK discards lock.
        check("pre_reset_locked", 32'(locked), 32'd1);
        do_reset("midcheck");
        clean(31);
        check("post_reset31_locked", 32'(locked), 32'd0);
        clean(1);
        check("post_reset32_locked", 32'(locked), 32'd1);

        // Random stress: sparse flips, enable gaps and clears.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 5) != 0),
                 (m_state == 2'd1) && ($urandom_range(0, 40) == 0),
                 ($urandom_range(0, 150) == 0), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
